// File: rtl/ram_burst_reader.sv
// Burst read master for the single-port-read RAM.
// Streams RAM words out over valid/ready through a 2-entry skid buffer.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic [ADDR_WIDTH-1:0] iReqAddr,
    input  logic [LEN_WIDTH-1:0]  iReqLen,
    output logic [ADDR_WIDTH-1:0] oRamReadAddress,
    input  logic [DATA_WIDTH-1:0] iRamDataOut,
    output logic                  oDataValid,
    input  logic                  iDataReady,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oDataLast,
    output logic                  oDone,
    output logic                  oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [LEN_WIDTH-1:0]  ONE       = LEN_WIDTH'(1);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  left;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buffer [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  req_fire;
    logic                  pop;
    logic                  last_pop;
    logic                  issue;

    // Occupancy the buffer would have if another read were launched now.
    assign req_fire = (state == IDLE) && iReqValid;
    assign pop      = (count != 2'd0) && iDataReady;
    assign last_pop = pop && (left == ONE);
    assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (state == READ) && (remaining != '0) && (occ < 3'd2);
    assign addr_inc = (next_addr == LAST_ADDR) ? '0 : next_addr + 1'b1;

    assign oRamReadAddress = issue ? next_addr : last_addr;
    assign oReqReady       = (state == IDLE);
    assign oBusy           = (state != IDLE);
    assign oDone           = (state == DONE);
    assign oDataValid      = (count != 2'd0);
    assign oData           = buffer[head];
    assign oDataLast       = oDataValid && (left == ONE);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: empty bursts skip straight to DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (iReqValid) begin
                    state_nxt = (iReqLen == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (last_pop)
                    state_nxt = DONE;
                else if (issue && (remaining == ONE))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_pop) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address generation, word counters and output buffer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            next_addr <= '0;
            last_addr <= '0;
            remaining <= '0;
            left      <= '0;
            inflight  <= 1'b0;
            buffer[0] <= '0;
            buffer[1] <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (req_fire) begin
                next_addr <= iReqAddr;
                remaining <= iReqLen;
                left      <= iReqLen;
            end else begin
                if (issue) begin
                    last_addr <= next_addr;
                    next_addr <= addr_inc;
                    remaining <= remaining - ONE;
                end
                if (pop) begin
                    left <= left - ONE;
                    head <= ~head;
                end
            end
            inflight <= issue;
            if (inflight) begin
                buffer[tail] <= iRamDataOut;
                tail         <= ~tail;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomised bench for ram_burst_reader with a RAM model
// and a word-queue reference model.
module tb_ram_burst_reader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic [7:0]  iReqAddr = '0;
    logic [7:0]  iReqLen = '0;
    logic [7:0]  oRamReadAddress;
    logic [15:0] iRamDataOut;
    logic        oDataValid;
    logic        iDataReady = 1'b0;
    logic [15:0] oData;
    logic        oDataLast;
    logic        oDone;
    logic        oBusy;

    int total = 0;
    int bad   = 0;

    ram_burst_reader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .MEM_SIZE(8),
        .LEN_WIDTH(8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iReqValid(iReqValid),
        .oReqReady(oReqReady),
        .iReqAddr(iReqAddr),
        .iReqLen(iReqLen),
        .oRamReadAddress(oRamReadAddress),
        .iRamDataOut(iRamDataOut),
        .oDataValid(oDataValid),
        .iDataReady(iDataReady),
        .oData(oData),
        .oDataLast(oDataLast),
        .oDone(oDone),
        .oBusy(oBusy)
    );

    always #5 Clock = ~Clock;

    // RAM: 9 words, registered read.
    logic [15:0] mem [0:8];
    logic [15:0] ram_q = '0;
    assign iRamDataOut = ram_q;

    always @(posedge Clock) begin
        if (oRamReadAddress <= 8'd8)
            ram_q <= mem[int'(oRamReadAddress)];
        else
            ram_q <= 16'hDEAD;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Reference model: expected words in order plus burst status.
    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t q[$];
    logic busy_exp = 1'b0;
    logic done_exp = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic prev_l = 1'b0;

    always @(negedge Clock) begin
        logic done_nxt;
        logic busy_nxt;
        if (Reset) begin
            q.delete();
            busy_exp   = 1'b0;
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            done_nxt = 1'b0;
            busy_nxt = busy_exp;
            chk("done", 32'(oDone), 32'(done_exp));
            chk("req_ready", 32'(oReqReady), 32'(!busy_exp));
            chk("busy", 32'(oBusy), 32'(busy_exp));
            if (prev_stall) begin
                chk("hold_valid", 32'(oDataValid), 32'd1);
                chk("hold_data", 32'(oData), 32'(prev_d));
                chk("hold_last", 32'(oDataLast), 32'(prev_l));
            end
            if (oDataValid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(oDataValid), 32'd0);
                end else begin
                    chk("data", 32'(oData), 32'(q[0].d));
                    chk("last", 32'(oDataLast), 32'(q[0].l));
                    if (iDataReady) begin
                        if (q[0].l) done_nxt = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end
            if (!busy_exp && iReqValid) begin
                for (int i = 0; i < int'(iReqLen); i++) begin
                    exp_t e;
                    e.d = mem[(int'(iReqAddr) + i) % 9];
                    e.l = (i == int'(iReqLen) - 1);
                    q.push_back(e);
                end
                if (iReqLen == 8'd0) done_nxt = 1'b1;
                busy_nxt = 1'b1;
            end
            if (done_exp) busy_nxt = 1'b0;
            prev_stall = oDataValid && !iDataReady;
            prev_d     = oData;
            prev_l     = oDataLast;
            done_exp   = done_nxt;
            busy_exp   = busy_nxt;
        end
    end

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy_exp && n < lim) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(busy_exp), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(oReqReady), 32'd1);
        chk({tag, "_addr"}, 32'(oRamReadAddress), 32'd0);
        chk({tag, "_valid"}, 32'(oDataValid), 32'd0);
        chk({tag, "_data"}, 32'(oData), 32'd0);
        chk({tag, "_last"}, 32'(oDataLast), 32'd0);
        chk({tag, "_done"}, 32'(oDone), 32'd0);
        chk({tag, "_busy"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got[$];
        int          ndone;
        int          cnt;
        int          n;
        logic [3:0]  pat;

        for (int i = 0; i < 9; i++) mem[i] = 16'($urandom);

        // Reset values.
        tick();
        tick();
        chk_reset_outs("rst");
        Reset = 1'b0;
        tick();

        // Basic burst, full throughput, literal timing.
        wait_idle(50);
        mem[2] = 16'hAAAA;
        mem[3] = 16'hBBBB;
        mem[4] = 16'hCCCC;
        mem[5] = 16'hDDDD;
        iDataReady = 1'b1;
        iReqAddr = 8'd2;
        iReqLen = 8'd4;
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
        chk("t1_addr_c1", 32'(oRamReadAddress), 32'd2);
        tick();
        chk("t1_addr_c2", 32'(oRamReadAddress), 32'd3);
        chk("t1_valid_c2", 32'(oDataValid), 32'd0);
        tick();
        chk("t1_valid_c3", 32'(oDataValid), 32'd1);
        chk("t1_w0", 32'(oData), 32'hAAAA);
        tick();
        chk("t1_w1", 32'(oData), 32'hBBBB);
        tick();
        chk("t1_w2", 32'(oData), 32'hCCCC);
        chk("t1_last_c5", 32'(oDataLast), 32'd0);
        tick();
        chk("t1_w3", 32'(oData), 32'hDDDD);
        chk("t1_last_c6", 32'(oDataLast), 32'd1);
        tick();
        chk("t1_done_c7", 32'(oDone), 32'd1);
        chk("t1_valid_c7", 32'(oDataValid), 32'd0);
        tick();
        chk("t1_ready_c8", 32'(oReqReady), 32'd1);
        chk("t1_done_c8", 32'(oDone), 32'd0);

        // Same burst under backpressure pattern 1,0,0,1.
        wait_idle(50);
        pat = 4'b1001;
        iReqAddr = 8'd2;
        iReqLen = 8'd4;
        iReqValid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            iDataReady = pat[k % 4];
            if (oDataValid && iDataReady) got.push_back(oData);
            tick();
            iReqValid = 1'b0;
        end
        chk("t2_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("t2_w0", 32'(got[0]), 32'hAAAA);
            chk("t2_w1", 32'(got[1]), 32'hBBBB);
            chk("t2_w2", 32'(got[2]), 32'hCCCC);
            chk("t2_w3", 32'(got[3]), 32'hDDDD);
        end

        // Address wrap 7 -> 8 -> 0.
        iDataReady = 1'b1;
        wait_idle(50);
        mem[7] = 16'h7777;
        mem[8] = 16'h8888;
        mem[0] = 16'h0F0F;
        iReqAddr = 8'd7;
        iReqLen = 8'd3;
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
        chk("t3_addr_c1", 32'(oRamReadAddress), 32'd7);
        tick();
        chk("t3_addr_c2", 32'(oRamReadAddress), 32'd8);
        tick();
        chk("t3_addr_c3", 32'(oRamReadAddress), 32'd0);
        chk("t3_w0", 32'(oData), 32'h7777);
        tick();
        chk("t3_w1", 32'(oData), 32'h8888);
        tick();
        chk("t3_w2", 32'(oData), 32'h0F0F);
        chk("t3_last", 32'(oDataLast), 32'd1);

        // Empty burst.
        wait_idle(50);
        chk("t4_addr_held", 32'(oRamReadAddress), 32'd0);
        iReqAddr = 8'd5;
        iReqLen = 8'd0;
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
        chk("t4_addr_c1", 32'(oRamReadAddress), 32'd0);
        chk("t4_done_c1", 32'(oDone), 32'd1);
        chk("t4_valid_c1", 32'(oDataValid), 32'd0);
        tick();
        chk("t4_done_c2", 32'(oDone), 32'd0);
        chk("t4_ready_c2", 32'(oReqReady), 32'd1);

        // Reset mid-burst after two words.
        wait_idle(50);
        iReqAddr = 8'd1;
        iReqLen = 8'd6;
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        Reset = 1'b1;
        tick();
        chk_reset_outs("t5");
        Reset = 1'b0;
        tick();
        chk("t5_no_done", 32'(oDone), 32'd0);
        chk("t5_no_valid", 32'(oDataValid), 32'd0);

        // Request held high: back-to-back bursts, fields sampled at accept.
        wait_idle(50);
        iDataReady = 1'b1;
        iReqLen = 8'd2;
        iReqValid = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            iReqAddr = 8'($urandom_range(0, 8));
            if (oDone) ndone++;
            tick();
        end
        iReqValid = 1'b0;
        chk("t6_dones", 32'(ndone), 32'd6);

        // Longest burst with no bubbles.
        wait_idle(50);
        iReqAddr = 8'd3;
        iReqLen = 8'd255;
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
        n = 0;
        while (!oDataValid && n < 10) begin
            tick();
            n++;
        end
        chk("long_latency", 32'(n), 32'd2);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if (oDataValid) cnt++;
            tick();
        end
        chk("long_stream", 32'(cnt), 32'd255);
        chk("long_done", 32'(oDone), 32'd1);

        // Randomised traffic.
        for (int k = 0; k < 2500; k++) begin
            iDataReady = ($urandom_range(0, 3) != 0);
            iReqValid  = ($urandom_range(0, 2) == 0);
            iReqAddr   = 8'($urandom_range(0, 8));
            iReqLen    = 8'($urandom_range(0, 9));
            if (!iReqValid && !busy_exp && $urandom_range(0, 1) == 1)
                mem[$urandom_range(0, 8)] = 16'($urandom);
            tick();
        end
        iReqValid = 1'b0;
        iDataReady = 1'b1;
        wait_idle(3000);
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
